// File: rtl/pipelined_control_unit_if.sv
// Bus between the ID stage and the pipelined control unit.
// The signal names match the original decoder ports so that existing
// datapath wiring can connect without renaming.
//   master : the IF/ID side. It drives i_valid, i_opcode, i_rs, i_rt and
//            i_flush, and it samples the stall and the stage controls.
//   slave  : the control unit. It samples the ID-stage fields and drives
//            the stall, the EX/MEM/WB controls and the illegal count.
interface pipelined_control_unit_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 4,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 8
);
  logic               i_valid;
  logic [OP_W-1:0]    i_opcode;
  logic [REG_W-1:0]   i_rs;
  logic [REG_W-1:0]   i_rt;
  logic               i_flush;

  logic               o_stall;
  logic               o_ex_RegDst;
  logic               o_ex_AluSrc;
  logic [ALUOP_W-1:0] o_ex_ALUop;
  logic [REG_W-1:0]   o_ex_rt;
  logic               o_mem_branch;
  logic               o_mem_Memread;
  logic               o_mem_MemWrite;
  logic               o_wb_MemtoReg;
  logic               o_wb_RegWrite;
  logic [CNT_W-1:0]   o_illegal_cnt;

  modport master (
    output i_valid, i_opcode, i_rs, i_rt, i_flush,
    input  o_stall, o_ex_RegDst, o_ex_AluSrc, o_ex_ALUop, o_ex_rt,
           o_mem_branch, o_mem_Memread, o_mem_MemWrite,
           o_wb_MemtoReg, o_wb_RegWrite, o_illegal_cnt
  );

  modport slave (
    input  i_valid, i_opcode, i_rs, i_rt, i_flush,
    output o_stall, o_ex_RegDst, o_ex_AluSrc, o_ex_ALUop, o_ex_rt,
           o_mem_branch, o_mem_Memread, o_mem_MemWrite,
           o_wb_MemtoReg, o_wb_RegWrite, o_illegal_cnt
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// Pipelined MIPS control unit.
// The block decodes the ID-stage opcode and carries the control bundle
// through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use
// hazards, applies branch flushes and keeps a saturating count of illegal
// opcodes.
// Ports:
//   i_clk   : clock, rising edge.
//   i_reset : synchronous, active-high reset. It discards every in-flight
//             bundle and clears the illegal count.
//   bus     : pipelined_control_unit_if.slave.
//             Inputs  : i_valid, i_opcode, i_rs, i_rt, i_flush (ID stage and
//                       branch resolution).
//             Outputs : o_stall (combinational), the EX, MEM and WB
//                       controls, o_ex_rt and o_illegal_cnt.
module pipelined_control_unit #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 4,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 8
) (
  input logic                    i_clk,
  input logic                    i_reset,
  pipelined_control_unit_if.slave bus
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);

  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic               branch;
  } ex_ctrl_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  ex_ctrl_t         dec;
  logic             illegal;
  logic             uses_rt;
  logic             stall;

  ex_ctrl_t         ex_q,  ex_d;
  logic [REG_W-1:0] ex_rt_q, ex_rt_d;
  mem_ctrl_t        mem_q, mem_d;
  wb_ctrl_t         wb_q,  wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Decode the ID-stage opcode. An illegal opcode produces the all-zero bundle.
  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    uses_rt = 1'b0;
    case (bus.i_opcode)
      OP_R: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_W'(2);
        uses_rt       = 1'b1;
      end
      OP_LW: begin
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu_op = ALUOP_W'(1);
        uses_rt    = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_ANDI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_W'(3);
      end
      OP_ORI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_W'(4);
      end
      OP_SLTI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_W'(5);
      end
      default: illegal = 1'b1;
    endcase
  end

  // Load-use hazard: a load in EX writes a register that the ID instruction
  // reads. rt counts as a source only for R-type, sw and beq. When a flush is
  // pending the stall is suppressed, because the flush turns the ID
  // instruction into a bubble anyway.
  always_comb begin
    stall = ex_q.mem_read & (ex_rt_q != '0) & bus.i_valid & ~bus.i_flush &
            ((ex_rt_q == bus.i_rs) | (uses_rt & (ex_rt_q == bus.i_rt)));
  end

  always_comb begin
    ex_d    = ex_q;
    ex_rt_d = ex_rt_q;
    mem_d   = '{branch:     ex_q.branch,
                mem_read:   ex_q.mem_read,
                mem_write:  ex_q.mem_write,
                mem_to_reg: ex_q.mem_to_reg,
                reg_write:  ex_q.reg_write};
    wb_d    = '{mem_to_reg: mem_q.mem_to_reg,
                reg_write:  mem_q.reg_write};
    cnt_d   = cnt_q;

    if (bus.i_flush) begin
      ex_d    = '0;
      ex_rt_d = '0;
      mem_d   = '0;
    end else if (stall) begin
      ex_d    = '0;
      ex_rt_d = '0;
    end else if (bus.i_valid && !illegal) begin
      ex_d    = dec;
      ex_rt_d = bus.i_rt;
    end else begin
      // An empty slot or an illegal instruction enters EX as a bubble.
      ex_d    = '0;
      ex_rt_d = '0;
    end

    if (bus.i_valid && illegal && !stall && !bus.i_flush && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_q    <= '0;
      ex_rt_q <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      ex_rt_q <= ex_rt_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_stall        = stall;
  assign bus.o_ex_RegDst    = ex_q.reg_dst;
  assign bus.o_ex_AluSrc    = ex_q.alu_src;
  assign bus.o_ex_ALUop     = ex_q.alu_op;
  assign bus.o_ex_rt        = ex_rt_q;
  assign bus.o_mem_branch   = mem_q.branch;
  assign bus.o_mem_Memread  = mem_q.mem_read;
  assign bus.o_mem_MemWrite = mem_q.mem_write;
  assign bus.o_wb_MemtoReg  = wb_q.mem_to_reg;
  assign bus.o_wb_RegWrite  = wb_q.reg_write;
  assign bus.o_illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
module tb_pipelined_control_unit;

  logic i_clk;
  logic i_reset;

  pipelined_control_unit_if #(.OP_W(6), .ALUOP_W(4), .REG_W(5), .CNT_W(8)) ifa ();
  pipelined_control_unit_if #(.OP_W(7), .ALUOP_W(5), .REG_W(5), .CNT_W(8)) ifb ();

  pipelined_control_unit #(.OP_W(6), .ALUOP_W(4), .REG_W(5), .CNT_W(8)) dut_a (
    .i_clk(i_clk), .i_reset(i_reset), .bus(ifa)
  );
  pipelined_control_unit #(.OP_W(7), .ALUOP_W(5), .REG_W(5), .CNT_W(8)) dut_b (
    .i_clk(i_clk), .i_reset(i_reset), .bus(ifb)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Decode table. Each row gives the opcode, then the flags
  // {RegDst, AluSrc, Memread, MemWrite, MemtoReg, RegWrite, branch},
  // then the ALU op.
  int     tbl_op  [8] = '{0, 35, 43, 4, 8, 12, 13, 10};
  bit [6:0] tbl_fl [8] = '{7'b1000010, 7'b0110110, 7'b0101000, 7'b0000001,
                           7'b0100010, 7'b0100010, 7'b0100010, 7'b0100010};
  int     tbl_alu [8] = '{2, 0, 0, 1, 0, 3, 4, 5};

  // Reference model. It tracks which table row occupies each pipeline slot,
  // with -1 standing for a bubble.
  int m_ex = -1, m_mem = -1, m_wb = -1, m_rt = 0, m_cnt = 0;

  function automatic int find(input int op);
    for (int i = 0; i < 8; i++) if (tbl_op[i] == op) return i;
    return -1;
  endfunction

  function automatic int flag(input int idx, input int bitpos);
    bit [6:0] f;
    if (idx < 0) return 0;
    f = tbl_fl[idx];
    return int'(f[6-bitpos]);
  endfunction

  function automatic int alu(input int idx);
    return (idx < 0) ? 0 : tbl_alu[idx];
  endfunction

  task automatic step(input bit v, input int op, input int rs, input int rt,
                      input bit fl, input bit rst);
    int  idx;
    bit  ur;
    bit  st;
    idx = find(op);
    ifa.i_valid = v;  ifa.i_opcode = 6'(op); ifa.i_rs = 5'(rs); ifa.i_rt = 5'(rt); ifa.i_flush = fl;
    ifb.i_valid = v;  ifb.i_opcode = 7'(op); ifb.i_rs = 5'(rs); ifb.i_rt = 5'(rt); ifb.i_flush = fl;
    i_reset = rst;
    @(negedge i_clk);
    ur = (idx == 0) || (idx == 2) || (idx == 3);
    st = (m_ex == 1) && (m_rt != 0) && v && !fl &&
         ((m_rt == rs) || (ur && (m_rt == rt)));

    check("A.stall",    int'(ifa.o_stall),        int'(st));
    check("A.RegDst",   int'(ifa.o_ex_RegDst),    flag(m_ex, 0));
    check("A.AluSrc",   int'(ifa.o_ex_AluSrc),    flag(m_ex, 1));
    check("A.ALUop",    int'(ifa.o_ex_ALUop),     alu(m_ex));
    check("A.ex_rt",    int'(ifa.o_ex_rt),        m_rt);
    check("A.branch",   int'(ifa.o_mem_branch),   flag(m_mem, 6));
    check("A.Memread",  int'(ifa.o_mem_Memread),  flag(m_mem, 2));
    check("A.MemWrite", int'(ifa.o_mem_MemWrite), flag(m_mem, 3));
    check("A.MemtoReg", int'(ifa.o_wb_MemtoReg),  flag(m_wb, 4));
    check("A.RegWrite", int'(ifa.o_wb_RegWrite),  flag(m_wb, 5));
    check("A.cnt",      int'(ifa.o_illegal_cnt),  m_cnt);

    check("B.stall",    int'(ifb.o_stall),        int'(st));
    check("B.RegDst",   int'(ifb.o_ex_RegDst),    flag(m_ex, 0));
    check("B.AluSrc",   int'(ifb.o_ex_AluSrc),    flag(m_ex, 1));
    check("B.ALUop",    int'(ifb.o_ex_ALUop),     alu(m_ex));
    check("B.ex_rt",    int'(ifb.o_ex_rt),        m_rt);
    check("B.branch",   int'(ifb.o_mem_branch),   flag(m_mem, 6));
    check("B.Memread",  int'(ifb.o_mem_Memread),  flag(m_mem, 2));
    check("B.MemWrite", int'(ifb.o_mem_MemWrite), flag(m_mem, 3));
    check("B.MemtoReg", int'(ifb.o_wb_MemtoReg),  flag(m_wb, 4));
    check("B.RegWrite", int'(ifb.o_wb_RegWrite),  flag(m_wb, 5));
    check("B.cnt",      int'(ifb.o_illegal_cnt),  m_cnt);

    if (rst) begin
      m_ex = -1; m_mem = -1; m_wb = -1; m_rt = 0; m_cnt = 0;
    end else begin
      if (v && idx < 0 && !st && !fl && m_cnt < 255) m_cnt++;
      m_wb = m_mem;
      if (fl) begin
        m_mem = -1; m_ex = -1; m_rt = 0;
      end else if (st) begin
        m_mem = m_ex; m_ex = -1; m_rt = 0;
      end else begin
        m_mem = m_ex;
        m_ex  = (v && idx >= 0) ? idx : -1;
        m_rt  = (v && idx >= 0) ? rt : 0;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    i_reset = 1'b1;
    ifa.i_valid = 1'b0; ifa.i_opcode = '0; ifa.i_rs = '0; ifa.i_rt = '0; ifa.i_flush = 1'b0;
    ifb.i_valid = 1'b0; ifb.i_opcode = '0; ifb.i_rs = '0; ifb.i_rt = '0; ifb.i_flush = 1'b0;
    @(posedge i_clk);
    #1;
    step(0, 0, 0, 0, 0, 1);

    // An R-type instruction walks through EX, MEM and WB.
    step(1, 0, 1, 2, 0, 0);
    idle(4);

    // A load followed by a dependent add stalls for one cycle, and the add is
    // presented again after the stall.
    step(1, 35, 0, 5, 0, 0);
    step(1, 0, 5, 6, 0, 0);
    step(1, 0, 5, 6, 0, 0);
    idle(4);

    // An addi does not read rt, so there is no stall.
    step(1, 35, 0, 5, 0, 0);
    step(1, 8, 3, 5, 0, 0);
    idle(3);

    // Register 0 never creates a hazard.
    step(1, 35, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(3);

    // A flush wins over the hazard: beq is in MEM, lw is in EX and a
    // dependent add is in ID.
    step(1, 4, 1, 2, 0, 0);
    step(1, 35, 0, 5, 0, 0);
    step(1, 0, 5, 6, 1, 0);
    idle(3);

    // The illegal-opcode counter saturates at 255.
    for (int i = 0; i < 259; i++) step(1, 63, 1, 1, 0, 0);
    idle(2);

    // An illegal opcode is not counted during a flush or a stall.
    step(1, 63, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 35, 0, 5, 0, 0);
    step(1, 63, 5, 0, 0, 0);
    idle(3);

    // A reset asserted mid-stream discards everything, including the lw in MEM.
    step(1, 35, 0, 1, 0, 0);
    step(1, 0, 2, 3, 0, 0);
    step(1, 8, 0, 0, 0, 1);
    idle(3);

    // Random traffic with small register numbers, to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      int op;
      if ($urandom_range(0, 7) < 7) op = tbl_op[$urandom_range(0, 7)];
      else op = int'($urandom_range(0, 63));
      step($urandom_range(0, 99) < 85, op, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
